// File: rtl/uart_cmd_framer.sv
// UART command framer: sequences a byte receiver into {cmd, data_hi, data_lo} frames with inter-byte timeout.
// Optional 4th checksum byte when UART_CMD_CHKSUM_EN is defined.
module uart_cmd_framer #(
    parameter int unsigned TIMEOUT_CLKS = 130208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frm_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GET_HI = 2'd1;
    localparam logic [1:0] GET_LO = 2'd2;
`ifdef UART_CMD_CHKSUM_EN
    localparam logic [1:0] GET_CK = 2'd3;
`endif

    localparam logic [17:0] TO_LAST = 18'(TIMEOUT_CLKS - 1);

    logic [1:0]  state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic [7:0]  stg_cmd_q, stg_cmd_d;
    logic [7:0]  stg_hi_q, stg_hi_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        accept;
    logic        timeout;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]  stg_lo_q, stg_lo_d;
    logic [7:0]  chk_sum;
`endif

    // Every state waits for a byte, so acceptance is simply rx_rdy outside reset.
    assign accept     = rx_rdy & rst_n;
    assign clr_rx_rdy = accept;
    assign timeout    = (cnt_q == TO_LAST);

`ifdef UART_CMD_CHKSUM_EN
    assign chk_sum = stg_cmd_q + stg_hi_q + stg_lo_q + rx_data;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stg_cmd_d = stg_cmd_q;
        stg_hi_d  = stg_hi_q;
`ifdef UART_CMD_CHKSUM_EN
        stg_lo_d  = stg_lo_q;
`endif
        cmd_d     = cmd_q;
        data_d    = data_q;
        cmd_rdy_d = cmd_rdy_q;
        frm_err_d = 1'b0;

        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    stg_cmd_d = rx_data;
                    cmd_rdy_d = 1'b0;
                    state_d   = GET_HI;
                end
            end

            GET_HI: begin
                if (accept) begin
                    stg_hi_d = rx_data;
                    cnt_d    = '0;
                    state_d  = GET_LO;
                end else if (timeout) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    frm_err_d = 1'b1;
                    stg_cmd_d = '0;
                    stg_hi_d  = '0;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end

            GET_LO: begin
                if (accept) begin
                    cnt_d = '0;
`ifdef UART_CMD_CHKSUM_EN
                    stg_lo_d = rx_data;
                    state_d  = GET_CK;
`else
                    // Commit directly from rx_data; the low byte never needs its own stage.
                    cmd_d     = stg_cmd_q;
                    data_d    = {stg_hi_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    state_d   = IDLE;
`endif
                end else if (timeout) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    frm_err_d = 1'b1;
                    stg_cmd_d = '0;
                    stg_hi_d  = '0;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end

`ifdef UART_CMD_CHKSUM_EN
            GET_CK: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (chk_sum == 8'hFF) begin
                        cmd_d     = stg_cmd_q;
                        data_d    = {stg_hi_q, stg_lo_q};
                        cmd_rdy_d = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    frm_err_d = 1'b1;
                    stg_cmd_d = '0;
                    stg_hi_d  = '0;
                    stg_lo_d  = '0;
                end else begin
                    cnt_d = cnt_q + 18'd1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stg_cmd_q <= '0;
            stg_hi_q  <= '0;
`ifdef UART_CMD_CHKSUM_EN
            stg_lo_q  <= '0;
`endif
            cmd_q     <= '0;
            data_q    <= '0;
            cmd_rdy_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stg_cmd_q <= stg_cmd_d;
            stg_hi_q  <= stg_hi_d;
`ifdef UART_CMD_CHKSUM_EN
            stg_lo_q  <= stg_lo_d;
`endif
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            cmd_rdy_q <= cmd_rdy_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign cmd_rdy = cmd_rdy_q;
    assign cmd     = cmd_q;
    assign data    = data_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: frame table plus timeout, reset and checksum sequences.
`timescale 1ns/1ps
module tb_uart_cmd_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frm_err;

    int errors = 0;
    int checks = 0;
    int n_clr  = 0;
    int n_err  = 0;

`ifdef UART_CMD_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    uart_cmd_framer #(.TIMEOUT_CLKS(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_rx_rdy) n_clr++;
        if (frm_err)    n_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required done)", $time);
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, ck;
        logic        clr_last;
        logic [7:0]  e_cmd;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one byte for a single cycle; clr_rx_rdy must follow rx_rdy combinationally.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(negedge clk);
        rx_rdy      = 1'b1;
        rx_data     = b;
        clr_cmd_rdy = clr;
        #1;
        check("clr_rx_rdy_hi", {31'd0, clr_rx_rdy}, 32'd1);
        @(negedge clk);
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        #1;
        check("clr_rx_rdy_lo", {31'd0, clr_rx_rdy}, 32'd0);
    endtask

    task automatic send_tail(input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] ck, input logic clr_last);
        send_byte(b1, 1'b0);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(b2, 1'b0);
        send_byte(ck, clr_last);
`else
        send_byte(b2, clr_last);
        if (ck === 8'hxx) $display("unused ck");
`endif
    endtask

    initial begin
        logic [7:0]  prev_cmd;
        logic [15:0] prev_data;
        int          c0, e0, k;
        logic        found;

        vecs[0] = '{b0:8'h05, b1:8'hA5, b2:8'h3C, ck:8'h19, clr_last:1'b0, e_cmd:8'h05, e_data:16'hA53C};
        vecs[1] = '{b0:8'h06, b1:8'h12, b2:8'h34, ck:8'hB3, clr_last:1'b0, e_cmd:8'h06, e_data:16'h1234};
        vecs[2] = '{b0:8'h80, b1:8'hFF, b2:8'h00, ck:8'h80, clr_last:1'b1, e_cmd:8'h80, e_data:16'hFF00};
        vecs[3] = '{b0:8'hFF, b1:8'hFF, b2:8'hFF, ck:8'h02, clr_last:1'b0, e_cmd:8'hFF, e_data:16'hFFFF};
        vecs[4] = '{b0:8'h00, b1:8'h00, b2:8'h00, ck:8'hFF, clr_last:1'b1, e_cmd:8'h00, e_data:16'h0000};

        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_cmd", {24'd0, cmd}, 32'h00);
        check("rst_data", {16'd0, data}, 32'h0000);
        check("rst_frm_err", {31'd0, frm_err}, 32'd0);
        check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        prev_cmd  = 8'h00;
        prev_data = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            c0 = n_clr;
            send_byte(vecs[i].b0, 1'b0);
            check("first_byte_clears_rdy", {31'd0, cmd_rdy}, 32'd0);
            check("hold_cmd", {24'd0, cmd}, {24'd0, prev_cmd});
            check("hold_data", {16'd0, data}, {16'd0, prev_data});
            send_tail(vecs[i].b1, vecs[i].b2, vecs[i].ck, vecs[i].clr_last);
            check("frame_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
            check("frame_cmd", {24'd0, cmd}, {24'd0, vecs[i].e_cmd});
            check("frame_data", {16'd0, data}, {16'd0, vecs[i].e_data});
            check("clr_rx_pulses", n_clr - c0, NB);
            prev_cmd  = vecs[i].e_cmd;
            prev_data = vecs[i].e_data;
        end

        // Consumer acknowledge clears cmd_rdy but keeps the frame.
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        check("ack_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("ack_cmd", {24'd0, cmd}, 32'h00);
        check("ack_data", {16'd0, data}, 32'h0000);

        // Commit a known frame, then let a partial one time out.
        send_byte(8'h05, 1'b0);
        send_tail(8'hA5, 8'h3C, 8'h19, 1'b0);
        e0 = n_err;
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        k = 0; found = 1'b0;
        while (k < 300 && !found) begin
            @(negedge clk);
            k++;
            if (frm_err) found = 1'b1;
        end
        check("timeout_latency", k, 100);
        @(negedge clk);
        check("timeout_pulse_end", {31'd0, frm_err}, 32'd0);
        check("timeout_err_count", n_err - e0, 1);
        check("timeout_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("timeout_cmd", {24'd0, cmd}, 32'h05);
        check("timeout_data", {16'd0, data}, 32'hA53C);
        send_byte(8'h0A, 1'b0);
        send_tail(8'h0B, 8'h0C, 8'hDE, 1'b0);
        check("post_to_cmd", {24'd0, cmd}, 32'h0A);
        check("post_to_data", {16'd0, data}, 32'h0B0C);
        check("post_to_rdy", {31'd0, cmd_rdy}, 32'd1);

        // A byte landing in the timeout cycle wins.
        e0 = n_err;
        send_byte(8'h01, 1'b0);
        repeat (98) @(negedge clk);
        send_tail(8'h02, 8'h03, 8'hF9, 1'b0);
        repeat (3) @(negedge clk);
        check("edge_byte_no_err", n_err - e0, 0);
        check("edge_byte_cmd", {24'd0, cmd}, 32'h01);
        check("edge_byte_data", {16'd0, data}, 32'h0203);
        check("edge_byte_rdy", {31'd0, cmd_rdy}, 32'd1);

        // Reset mid-frame discards the partial frame.
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("midrst_cmd", {24'd0, cmd}, 32'h00);
        check("midrst_data", {16'd0, data}, 32'h0000);
        @(negedge clk); rst_n = 1'b1;
        send_byte(8'h07, 1'b0);
        send_tail(8'h00, 8'h01, 8'hF7, 1'b0);
        check("after_rst_cmd", {24'd0, cmd}, 32'h07);
        check("after_rst_data", {16'd0, data}, 32'h0001);
        check("after_rst_rdy", {31'd0, cmd_rdy}, 32'd1);

`ifdef UART_CMD_CHKSUM_EN
        e0 = n_err;
        send_byte(8'h05, 1'b0);
        send_tail(8'hA5, 8'h3C, 8'h18, 1'b0);
        check("bad_ck_err", {31'd0, frm_err}, 32'd1);
        check("bad_ck_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("bad_ck_cmd", {24'd0, cmd}, 32'h07);
        check("bad_ck_data", {16'd0, data}, 32'h0001);
        @(negedge clk);
        check("bad_ck_pulse", n_err - e0, 1);
        send_byte(8'h05, 1'b0);
        send_tail(8'hA5, 8'h3C, 8'h19, 1'b0);
        check("good_ck_err", {31'd0, frm_err}, 32'd0);
        check("good_ck_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("good_ck_cmd", {24'd0, cmd}, 32'h05);
        check("good_ck_data", {16'd0, data}, 32'hA53C);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
